// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM state
// encoding and default widths for data and register addresses.
package alu_seq_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int AW_DEFAULT = 5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

endpackage

// File: rtl/alu8.sv
// Purely combinational two-operand ALU. Carry means carry-out for ADD,
// borrow for SUB, and the bit shifted out for SHL/SHR; zero otherwise.
module alu8
  import alu_seq_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y,
  output logic          carry,
  output logic          zero,
  output logic          negative
);

  logic [DW:0] wide;

  // Opcode decode; the extra MSB of 'wide' holds carry-out or borrow.
  always_comb begin
    y     = '0;
    carry = 1'b0;
    wide  = '0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        y     = wide[DW-1:0];
        carry = wide[DW];
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        y     = wide[DW-1:0];
        carry = wide[DW];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SHL: begin
        y     = {a[DW-2:0], 1'b0};
        carry = a[DW-1];
      end
      OP_SHR: begin
        y     = {1'b0, a[DW-1:1]};
        carry = a[0];
      end
      default: y = '0;
    endcase
  end

  assign zero     = (y == '0);
  assign negative = y[DW-1];

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences a single-port register file through read A, read B, execute and
// write-back for one two-operand ALU request at a time. The register file
// registers data_out on the rising edge and writes on the falling edge, so
// every address is presented one cycle before its data is captured.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE and never while
// reset is asserted; the requester keeps req_valid and the fields stable
// until the transfer, and anything presented while not ready is ignored.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_rd,
  input  logic [AW-1:0] req_rs1,
  input  logic [AW-1:0] req_rs2,
  output logic [AW-1:0] rf_address,
  output logic [DW-1:0] rf_data_in,
  output logic          rf_enable,
  input  logic [DW-1:0] rf_data_out,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          flag_z,
  output logic          flag_c,
  output logic          flag_n,
  output state_t        dbg_state
);

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] rs2_q, rs2_d;
  logic [DW-1:0] a_q, a_d;
  logic [AW-1:0] rf_address_q, rf_address_d;
  logic [DW-1:0] rf_data_in_q, rf_data_in_d;
  logic          rf_enable_q, rf_enable_d;
  logic          pend_c_q, pend_c_d;
  logic          pend_z_q, pend_z_d;
  logic          pend_n_q, pend_n_d;
  logic          done_q, done_d;
  logic [DW-1:0] result_q, result_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_c_q, flag_c_d;
  logic          flag_n_q, flag_n_d;

  logic [DW-1:0] alu_y;
  logic          alu_c;
  logic          alu_z;
  logic          alu_n;

  // Operand B is consumed straight from the register file in EXEC; the
  // result register (rf_data_in) is where it effectively gets captured.
  alu8 #(
    .DW(DW)
  ) u_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (rf_data_out),
    .y        (alu_y),
    .carry    (alu_c),
    .zero     (alu_z),
    .negative (alu_n)
  );

  // Next-state and next-output logic for the read/read/exec/write sequence.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    rs2_d        = rs2_q;
    a_d          = a_q;
    rf_address_d = rf_address_q;
    rf_data_in_d = rf_data_in_q;
    rf_enable_d  = rf_enable_q;
    pend_c_d     = pend_c_q;
    pend_z_d     = pend_z_q;
    pend_n_d     = pend_n_q;
    done_d       = 1'b0;
    result_d     = result_q;
    flag_z_d     = flag_z_q;
    flag_c_d     = flag_c_q;
    flag_n_d     = flag_n_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d         = req_op;
          rd_d         = req_rd;
          rs2_d        = req_rs2;
          rf_address_d = req_rs1;
          state_d      = S_RD_A;
        end
      end
      S_RD_A: begin
        rf_address_d = rs2_q;
        state_d      = S_RD_B;
      end
      S_RD_B: begin
        a_d     = rf_data_out;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        rf_address_d = rd_q;
        rf_data_in_d = alu_y;
        rf_enable_d  = 1'b1;
        pend_c_d     = alu_c;
        pend_z_d     = alu_z;
        pend_n_d     = alu_n;
        state_d      = S_WB;
      end
      S_WB: begin
        rf_enable_d = 1'b0;
        done_d      = 1'b1;
        result_d    = rf_data_in_q;
        flag_z_d    = pend_z_q;
        flag_c_d    = pend_c_q;
        flag_n_d    = pend_n_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything, which also
  // cancels a pending write if it lands before write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      rd_q         <= '0;
      rs2_q        <= '0;
      a_q          <= '0;
      rf_address_q <= '0;
      rf_data_in_q <= '0;
      rf_enable_q  <= 1'b0;
      pend_c_q     <= 1'b0;
      pend_z_q     <= 1'b0;
      pend_n_q     <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      flag_z_q     <= 1'b0;
      flag_c_q     <= 1'b0;
      flag_n_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      rs2_q        <= rs2_d;
      a_q          <= a_d;
      rf_address_q <= rf_address_d;
      rf_data_in_q <= rf_data_in_d;
      rf_enable_q  <= rf_enable_d;
      pend_c_q     <= pend_c_d;
      pend_z_q     <= pend_z_d;
      pend_n_q     <= pend_n_d;
      done_q       <= done_d;
      result_q     <= result_d;
      flag_z_q     <= flag_z_d;
      flag_c_q     <= flag_c_d;
      flag_n_q     <= flag_n_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign rf_address = rf_address_q;
  assign rf_data_in = rf_data_in_q;
  assign rf_enable  = rf_enable_q;
  assign done       = done_q;
  assign result     = result_q;
  assign flag_z     = flag_z_q;
  assign flag_c     = flag_c_q;
  assign flag_n     = flag_n_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural 32x8 register file on the DUT's
// port, directed scenarios followed by randomized operations, all checked
// against a shadow register array and an arithmetic ALU model.
module tb_alu_op_sequencer;

  localparam int DW = 8;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_rd, req_rs1, req_rs2;
  logic [AW-1:0] rf_address;
  logic [DW-1:0] rf_data_in;
  logic          rf_enable;
  logic [DW-1:0] rf_data_out;
  logic          done;
  logic [DW-1:0] result;
  logic          flag_z, flag_c, flag_n;
  alu_seq_pkg::state_t dbg_state;

  alu_op_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .rf_address  (rf_address),
    .rf_data_in  (rf_data_in),
    .rf_enable   (rf_enable),
    .rf_data_out (rf_data_out),
    .done        (done),
    .result      (result),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .flag_n      (flag_n),
    .dbg_state   (dbg_state)
  );

  // ---------------- register file environment ----------------
  logic [DW-1:0] mem [32];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) rf_data_out <= mem[rf_address];

  always @(negedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (rf_enable) mem[rf_address] <= rf_data_in;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0]   ref_mem [32];
  logic [DW+2:0]   exp_q[$];
  int checks = 0;
  int errors = 0;

  // Returns {result, z, c, n} from the opcode definitions.
  function automatic logic [DW+2:0] model(input logic [2:0] op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic          c;
    int            s;
    c = 1'b0;
    r = '0;
    case (op)
      3'd0: begin s = int'(a) + int'(b); r = 8'(s % 256); c = (s > 255); end
      3'd1: begin s = int'(a) - int'(b); r = 8'((s + 256) % 256); c = (int'(a) < int'(b)); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = 8'(255 - int'(a));
      3'd6: begin r = 8'((int'(a) * 2) % 256); c = (int'(a) >= 128); end
      default: begin r = 8'(int'(a) / 2); c = (int'(a) % 2 == 1); end
    endcase
    return {r, (r == 8'd0), c, (int'(r) >= 128)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(posedge clk);
    #1;
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    @(negedge clk);
    #1;
    pl_en = 1'b0;
    ref_mem[addr] = data;
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [AW-1:0] rd,
                           input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
  endtask

  task automatic scramble_req();
    req_op  = 3'($urandom_range(0, 7));
    req_rd  = 5'($urandom_range(0, 31));
    req_rs1 = 5'($urandom_range(0, 31));
    req_rs2 = 5'($urandom_range(0, 31));
  endtask

  // Issues one op (called away from posedge, DUT idle) and returns in the
  // done cycle, so a following call issues back-to-back.
  task automatic do_op(input bit hold, input logic [2:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    logic [DW+2:0] e;
    int cyc, en_cnt, busy_cnt;
    check("ready_at_issue", 32'(req_ready), 1);
    exp_q.push_back(model(op, ref_mem[rs1], ref_mem[rs2]));
    e = exp_q[$];
    drive_req(op, rd, rs1, rs2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; en_cnt = 0; busy_cnt = 0;
    while (!done && cyc < 12) begin
      if (rf_enable) begin
        en_cnt++;
        check("wb_addr", 32'(rf_address), 32'(rd));
        check("wb_data", 32'(rf_data_in), 32'(e[DW+2:3]));
      end
      if (!req_ready) busy_cnt++;
      if (hold) begin
        req_valid = 1'b1;
        scramble_req();
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    check("done_seen", 32'(done), 1);
    check("latency", 32'(cyc - 1), 4);
    check("enable_cycles", 32'(en_cnt), 1);
    if (hold) check("busy_cycles", 32'(busy_cnt), 4);
    e = exp_q.pop_front();
    check("result", 32'(result), 32'(e[DW+2:3]));
    check("flag_z", 32'(flag_z), 32'(e[2]));
    check("flag_c", 32'(flag_c), 32'(e[1]));
    check("flag_n", 32'(flag_n), 32'(e[0]));
    check("rf_write", 32'(mem[rd]), 32'(e[DW+2:3]));
    ref_mem[rd] = e[DW+2:3];
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_enable"}, 32'(rf_enable), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_flags"}, 32'({flag_z, flag_c, flag_n}), 0);
    check({tag, "_addr"}, 32'(rf_address), 0);
    check({tag, "_data"}, 32'(rf_data_in), 0);
    check({tag, "_ready"}, 32'(req_ready), 0);
  endtask

  // Reset sampled at the EXEC boundary: the write must never happen.
  task automatic reset_in_exec(input logic [2:0] op, input logic [AW-1:0] rd,
                               input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    drive_req(op, rd, rs1, rs2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_cleared("rst_exec");
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_exec_ready", 32'(req_ready), 1);
      check("rst_exec_no_done", 32'(done), 0);
    end
    check("rst_exec_no_write", 32'(mem[rd]), 32'(ref_mem[rd]));
  endtask

  // Reset sampled at the end of write-back: write lands, done suppressed.
  task automatic reset_in_wb(input logic [2:0] op, input logic [AW-1:0] rd,
                             input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    logic [DW+2:0] e;
    e = model(op, ref_mem[rs1], ref_mem[rs2]);
    drive_req(op, rd, rs1, rs2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wb_enable_high", 32'(rf_enable), 1);
    reset = 1'b1;
    @(negedge clk);
    check_cleared("rst_wb");
    check("rst_wb_write_done", 32'(mem[rd]), 32'(e[DW+2:3]));
    ref_mem[rd] = e[DW+2:3];
    reset = 1'b0;
    @(negedge clk);
    check("rst_wb_ready", 32'(req_ready), 1);
    check("rst_wb_no_done", 32'(done), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    check("reset_state", 32'(dbg_state), 0);

    for (int i = 0; i < 32; i++) preload(5'(i), 8'($urandom_range(0, 255)));
    preload(5'd1, 8'h0F);
    preload(5'd2, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ADD R3 = R1 + R2
    do_op(1'b0, 3'd0, 5'd3, 5'd1, 5'd2);
    check("add_r3_value", 32'(result), 32'h10);

    // ADD into rs1, then XOR reading it in the done cycle
    preload(5'd1, 8'hFF);
    do_op(1'b0, 3'd0, 5'd1, 5'd1, 5'd2);
    check("add_wrap_zc", 32'({result, flag_z, flag_c}), 32'({8'h00, 1'b1, 1'b1}));
    do_op(1'b0, 3'd4, 5'd8, 5'd1, 5'd1);
    check("xor_raw", 32'({result, flag_z}), 32'({8'h00, 1'b1}));

    // SUB with borrow, then SHR of its result
    preload(5'd4, 8'h05);
    preload(5'd5, 8'h07);
    do_op(1'b0, 3'd1, 5'd6, 5'd4, 5'd5);
    check("sub_borrow", 32'({result, flag_c, flag_n}), 32'({8'hFE, 1'b1, 1'b1}));
    do_op(1'b0, 3'd7, 5'd7, 5'd6, 5'd0);
    check("shr_value", 32'({result, flag_c}), 32'({8'h7F, 1'b0}));

    // Busy requester with changing fields
    do_op(1'b1, 3'd3, 5'd10, 5'd3, 5'd6);
    for (int i = 0; i < 32; i++) check("mem_after_busy", 32'(mem[i]), 32'(ref_mem[i]));

    // Reset mid-operation
    preload(5'd9, 8'h55);
    reset_in_exec(3'd0, 5'd9, 5'd4, 5'd5);
    preload(5'd11, 8'hAA);
    reset_in_wb(3'd1, 5'd11, 5'd5, 5'd4);

    // Randomized operations with random gaps
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op((i % 8) == 3, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    @(negedge clk);
    for (int i = 0; i < 32; i++) check("mem_final", 32'(mem[i]), 32'(ref_mem[i]));
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
